// File: rtl/seq_binary_multiplier.sv
// rtl/seq_binary_multiplier.sv - multi-cycle shift-add multiplier, unsigned or two's-complement signed
module seq_binary_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     hi;
    logic [WIDTH:0]     mcand;
    logic [WIDTH-1:0]   lo;
    logic               sgn;
    logic               last;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;

    // hi is kept sign-extended; in signed mode the multiplier MSB carries negative weight,
    // so the last iteration subtracts the multiplicand instead of adding it.
    always_comb begin
        last   = (cnt == CW'(1));
        addend = '0;
        if (lo[0]) begin
            addend = (last && sgn) ? -{mcand[WIDTH], mcand} : {mcand[WIDTH], mcand};
        end
        sum = {hi[WIDTH], hi} + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            sgn   <= 1'b0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        mcand <= signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
                        lo    <= b;
                        hi    <= '0;
                        sgn   <= signed_mode;
                        cnt   <= CW'(WIDTH);
                    end
                end
                BUSY: begin
                    hi  <= sum[WIDTH+1:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        p     <= {sum[WIDTH:0], lo[WIDTH-1:1]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
